uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Start bit is qualified at mid-bit; data and stop bits are sampled one bit period apart from there.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            sync_q, rxs_q;
  logic            deliver;
  logic            hs;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
    hs      = valid_q & rx_ready_i;

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = StData;
            idx_d   = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          shift_d[idx_q] = rxs_q;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs_q) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitHigh: begin
        // A held-low line (break) must not be re-read as a stream of frames.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A handshake in the delivery cycle frees the slot for the incoming byte.
    if (deliver) begin
      if (!valid_q || hs) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= uart_i;
      rxs_q   <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded random/directed bench for uart_receiver: the driver queues the expected event per
// frame, and a monitor pops and compares whenever the DUT delivers a byte or pulses an error.
module tb_uart_receiver;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart;
  logic       ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ferr;
  logic       ovr;

  uart_receiver #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .uart_i     (uart),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (ready),
    .frame_err_o(ferr),
    .overrun_o  (ovr)
  );

  always #5 clk = ~clk;

  typedef enum int {EvData, EvFerr, EvOvr} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   buf_full = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic pop_cmp(input ev_e kind, input logic [7:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: actual kind %0d data %02h required no event", kind, d);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
    if (kind == EvData && e.kind == EvData) check("rx_data", {24'h0, d}, {24'h0, e.data});
  endtask

  // Reference: a good frame fills the one-entry buffer unless it is already full and nobody
  // is draining it; a bad stop bit only ever reports a frame error.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int low_extra);
    exp_t e;
    e.data = 8'h00;
    if (!stop_ok) begin
      e.kind = EvFerr;
    end else if (buf_full && !ready) begin
      e.kind = EvOvr;
    end else begin
      e.kind   = EvData;
      e.data   = b;
      buf_full = !ready;
    end
    exp_q.push_back(e);
    uart = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      tick(Cpb);
    end
    uart = stop_ok;
    tick(Cpb);
    if (!stop_ok) begin
      tick(low_extra);
      uart = 1'b1;
      tick(Cpb);
    end
    uart = 1'b1;
  endtask

  task automatic drain();
    ready = 1'b1;
    tick(2);
    ready    = 1'b0;
    buf_full = 1'b0;
  endtask

  // Monitor
  bit         prev_valid = 1'b0;
  bit         prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("ferr_ovr_exclusive", {31'h0, ferr & ovr}, 32'h0);
      if (ferr) pop_cmp(EvFerr, 8'h00);
      if (ovr) pop_cmp(EvOvr, 8'h00);
      if (rx_valid && (!prev_valid || prev_hs)) pop_cmp(EvData, rx_data);
      else if (rx_valid && prev_valid) check("data_stable", {24'h0, rx_data}, {24'h0, prev_data});
    end
    prev_valid = rx_valid;
    prev_hs    = rx_valid & ready;
    prev_data  = rx_data;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    uart  = 1'b1;
    ready = 1'b0;
    tick(3);
    check("rst_data", {24'h0, rx_data}, 32'h0);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_ferr", {31'h0, ferr}, 32'h0);
    check("rst_ovr", {31'h0, ovr}, 32'h0);
    rst = 1'b0;
    tick(4);

    // Single byte held, then one-cycle accept
    send(8'hA5, 1'b1, 0);
    tick(4);
    check("a5_valid", {31'h0, rx_valid}, 32'h1);
    check("a5_data", {24'h0, rx_data}, 32'hA5);
    ready = 1'b1;
    tick(1);
    ready    = 1'b0;
    buf_full = 1'b0;
    check("hs_clears_valid", {31'h0, rx_valid}, 32'h0);
    check("hs_keeps_data", {24'h0, rx_data}, 32'hA5);

    // Short glitch is rejected
    tick(8);
    uart = 1'b0;
    tick(4);
    uart = 1'b1;
    tick(12);
    check("glitch_no_valid", {31'h0, rx_valid}, 32'h0);

    // Bad stop bit followed by a break, then a clean frame
    send(8'h3C, 1'b0, 40);
    check("ferr_no_valid", {31'h0, rx_valid}, 32'h0);
    send(8'h5A, 1'b1, 0);
    tick(4);
    check("after_ferr_data", {24'h0, rx_data}, 32'h5A);
    drain();

    // Overrun: second byte dropped, first retained
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b1, 0);
    tick(4);
    check("ovr_data_kept", {24'h0, rx_data}, 32'h11);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    drain();

    // Streaming with the consumer always ready
    ready = 1'b1;
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    send(8'h81, 1'b1, 0);
    tick(4);
    ready = 1'b0;
    tick(2);

    // Reset in the middle of bit 4; the sender abandons the frame too
    send_abort();
    tick(Cpb);
    send(8'h96, 1'b1, 0);
    tick(4);
    check("post_rst_data", {24'h0, rx_data}, 32'h96);
    drain();

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      ready = 1'($urandom_range(0, 1));
      tick(2 + $urandom_range(0, 20));
      if (ready) buf_full = 1'b0;
      send(8'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(0, 40));
    end

    ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic send_abort();
    logic [7:0] b;
    b    = 8'hC3;
    uart = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 4; i++) begin
      uart = b[i];
      tick(Cpb);
    end
    uart = b[4];
    tick(Cpb / 2);
    rst  = 1'b1;
    uart = 1'b1;
    tick(1);
    check("abort_data", {24'h0, rx_data}, 32'h0);
    check("abort_valid", {31'h0, rx_valid}, 32'h0);
    check("abort_ferr", {31'h0, ferr}, 32'h0);
    check("abort_ovr", {31'h0, ovr}, 32'h0);
    rst      = 1'b0;
    buf_full = 1'b0;
  endtask

endmodule
